// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the instruction memory and its loader.
//   INSTR_W        : instruction word width in bits
//   BYTES_PER_WORD : program bytes per instruction word
//   state_e        : loader FSM states
//   word_addr()    : byte address of a word index, also used by the memory's read path
package cpu_mem_pkg;

  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRecv,
    StWrite,
    StDone
  } state_e;

  function automatic logic [INSTR_W-1:0] word_addr(input logic [INSTR_W-1:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles a big-endian byte stream into 32-bit words.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clear_i       : drop any partial word
//   push_i        : byte_i is consumed this cycle
//   last_i        : byte_i is the final program byte (ends the word early)
//   byte_i        : incoming byte
//   word_o        : word including byte_i, zero-padded below byte_i
//   word_full_o   : byte_i is the 4th byte of the current word
module byte_packer
  import cpu_mem_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic               last_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_full_o
);

  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  // word_o already contains the current byte so the writer can register it
  // on the same edge the byte is accepted.
  always_comb begin
    word_o = '0;
    unique case (idx_q)
      2'd0:    word_o = {byte_i, 24'h0};
      2'd1:    word_o = {shift_q[7:0], byte_i, 16'h0};
      2'd2:    word_o = {shift_q[15:0], byte_i, 8'h0};
      default: word_o = {shift_q, byte_i};
    endcase
  end

  assign word_full_o = (idx_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (push_i) begin
      if (word_full_o || last_i) begin
        shift_q <= '0;
        idx_q   <= '0;
      end else begin
        shift_q <= {shift_q[15:0], byte_i};
        idx_q   <= idx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program into the instruction memory from a byte stream.
// Zero-fills the memory, then writes assembled big-endian words to consecutive
// addresses while holding the CPU in reset.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   start_i              : begin a load (honoured in idle/done only)
//   byte_i/_valid_i/_last_i, byte_ready_o : byte stream handshake
//   wr_en_o/_addr_o/_data_o : instruction memory write port
//   cpu_hold_o           : keep CPU in reset
//   done_o               : load complete
//   err_align_o          : final byte did not complete a word (sticky)
//   err_ovf_o            : program larger than memory (sticky)
//   words_o              : program words written
module instr_mem_loader
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned CNT_W     = $clog2(MEM_WORDS) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  input  logic               byte_last_i,
  output logic               byte_ready_o,
  output logic               wr_en_o,
  output logic [INSTR_W-1:0] wr_addr_o,
  output logic [INSTR_W-1:0] wr_data_o,
  output logic               cpu_hold_o,
  output logic               done_o,
  output logic               err_align_o,
  output logic               err_ovf_o,
  output logic [CNT_W-1:0]   words_o
);

  localparam logic [CNT_W-1:0] MemWordsC = CNT_W'(MEM_WORDS);

  state_e               state_q;
  logic [CNT_W-1:0]     clr_idx_q;
  logic [CNT_W-1:0]     word_idx_q;
  logic                 ready_q;
  logic                 wr_en_q;
  logic [INSTR_W-1:0]   wr_addr_q;
  logic [INSTR_W-1:0]   wr_data_q;
  logic                 hold_q;
  logic                 done_q;
  logic                 err_align_q;
  logic                 err_ovf_q;
  logic                 last_word_q;

  logic                 start_ok;
  logic                 draining;
  logic                 accept;
  logic                 push;
  logic [INSTR_W-1:0]   word;
  logic                 word_full;

  assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));
  // Memory full: remaining bytes are accepted and discarded.
  assign draining = (word_idx_q == MemWordsC);
  assign accept   = (state_q == StRecv) && byte_valid_i && ready_q;
  assign push     = accept && !draining;

  byte_packer u_byte_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (start_ok),
    .push_i      (push),
    .last_i      (byte_last_i),
    .byte_i      (byte_i),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      clr_idx_q   <= '0;
      word_idx_q  <= '0;
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      err_align_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      last_word_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            // First clear write (k=0) is issued straight away.
            state_q     <= StClear;
            hold_q      <= 1'b1;
            done_q      <= 1'b0;
            err_align_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            word_idx_q  <= '0;
            clr_idx_q   <= CNT_W'(1);
            last_word_q <= 1'b0;
            wr_en_q     <= 1'b1;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
          end
        end
        StClear: begin
          if (clr_idx_q == MemWordsC) begin
            state_q <= StRecv;
            wr_en_q <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            wr_addr_q <= word_addr(INSTR_W'(clr_idx_q));
            clr_idx_q <= clr_idx_q + CNT_W'(1);
          end
        end
        StRecv: begin
          if (accept) begin
            if (draining) begin
              err_ovf_q <= 1'b1;
              if (byte_last_i) begin
                state_q <= StDone;
                ready_q <= 1'b0;
                hold_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else if (word_full || byte_last_i) begin
              state_q     <= StWrite;
              ready_q     <= 1'b0;
              wr_en_q     <= 1'b1;
              wr_addr_q   <= word_addr(INSTR_W'(word_idx_q));
              wr_data_q   <= word;
              last_word_q <= byte_last_i;
              if (byte_last_i && !word_full) begin
                err_align_q <= 1'b1;
              end
            end
          end
        end
        StWrite: begin
          wr_en_q    <= 1'b0;
          word_idx_q <= word_idx_q + CNT_W'(1);
          if (last_word_q) begin
            state_q <= StDone;
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StRecv;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign byte_ready_o = ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign err_align_o  = err_align_q;
  assign err_ovf_o    = err_ovf_q;
  // Writes stop at MEM_WORDS, so the word index saturates there on its own.
  assign words_o      = word_idx_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int unsigned MEM_WORDS = 32;
  localparam int unsigned CNT_W     = 6;

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic [7:0]       byte_i;
  logic             byte_valid_i;
  logic             byte_last_i;
  logic             byte_ready_o;
  logic             wr_en_o;
  logic [31:0]      wr_addr_o;
  logic [31:0]      wr_data_o;
  logic             cpu_hold_o;
  logic             done_o;
  logic             err_align_o;
  logic             err_ovf_o;
  logic [CNT_W-1:0] words_o;

  instr_mem_loader #(
    .MEM_WORDS (MEM_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_last_i  (byte_last_i),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .cpu_hold_o   (cpu_hold_o),
    .done_o       (done_o),
    .err_align_o  (err_align_o),
    .err_ovf_o    (err_ovf_o),
    .words_o      (words_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          ready_bad = 0;
  logic [7:0]  stream[$];
  int          acc_cyc[$];
  logic [31:0] exp_data[$];

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en_o) begin
      log_addr.push_back(wr_addr_o);
      log_data.push_back(wr_data_o);
      log_cyc.push_back(cyc);
    end
    if (byte_ready_o && wr_en_o) ready_bad++;
  end

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    exp_data.delete();
    for (int k = 0; k < MEM_WORDS; k++) exp_data.push_back(32'h0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_stream(input bit toggle, input bit mark_last, output bit ok);
    ok = 1'b1;
    acc_cyc.delete();
    for (int i = 0; i < stream.size(); i++) begin
      bit got;
      bit sampled;
      int budget;
      got = 1'b0;
      budget = 0;
      if (toggle && i > 0) begin
        @(negedge clk);
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
      end
      while (!got) begin
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_i       = stream[i];
        byte_last_i  = mark_last && (i == stream.size() - 1);
        sampled      = byte_ready_o;
        @(posedge clk);
        #1;
        if (sampled) begin
          got = 1'b1;
          acc_cyc.push_back(cyc);
        end else if (++budget > 200) begin
          ok = 1'b0;
          byte_valid_i = 1'b0;
          byte_last_i  = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int dcyc);
    ok = 1'b0;
    dcyc = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        dcyc = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bit found;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    checks++;
    if ({byte_ready_o, wr_en_o, cpu_hold_o, done_o, err_align_o, err_ovf_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got %b expected 000000",
               {byte_ready_o, wr_en_o, cpu_hold_o, done_o, err_align_o, err_ovf_o});
    end
    checks++;
    if (wr_addr_o !== 32'h0 || wr_data_o !== 32'h0 || words_o !== '0) begin
      failures++;
      $display("FAIL reset_buses got addr=%h data=%h words=%0d expected 0", wr_addr_o,
               wr_data_o, words_o);
    end
    // Reset while the k=10 clear write is on the bus.
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (wr_en_o && wr_addr_o == 32'h28) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin
      failures++;
      $display("FAIL reset_reach_k10 got found=%0b expected 1", found);
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checks++;
    if ({byte_ready_o, wr_en_o, cpu_hold_o, done_o, err_align_o, err_ovf_o} !== 6'b0 ||
        wr_addr_o !== 32'h0 || wr_data_o !== 32'h0 || words_o !== '0) begin
      failures++;
      $display("FAIL midclear_reset got en=%b hold=%b addr=%h data=%h expected all 0",
               wr_en_o, cpu_hold_o, wr_addr_o, wr_data_o);
    end
    clear_logs();
    repeat (40) @(negedge clk);
    checks++;
    if (log_addr.size() !== 0) begin
      failures++;
      $display("FAIL post_reset_writes got %0d expected 0", log_addr.size());
    end
    checks++;
    if ({cpu_hold_o, byte_ready_o, done_o} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle got hold/ready/done=%b expected 000",
               {cpu_hold_o, byte_ready_o, done_o});
    end
  endtask

  task automatic run_program(input string name, input bit toggle);
    bit ok;
    bit dok;
    int dcyc;
    logic [31:0] ea;
    clear_logs();
    exp_data.push_back(32'h20080005);
    exp_data.push_back(32'h00000000);
    stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    ready_bad = 0;
    pulse_start();
    checks++;
    if (cpu_hold_o !== 1'b1 || byte_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_clear_hold got hold=%b ready=%b expected hold=1 ready=0", name,
               cpu_hold_o, byte_ready_o);
    end
    send_stream(toggle, 1'b1, ok);
    wait_done(dok, dcyc);
    checks++;
    if ({ok, dok} !== 2'b11) begin
      failures++;
      $display("FAIL %s_timeout got sent=%b done=%b expected 11", name, ok, dok);
    end
    checks++;
    if (log_data.size() !== exp_data.size()) begin
      failures++;
      $display("FAIL %s_nwrites got %0d expected %0d", name, log_data.size(), exp_data.size());
    end
    for (int j = 0; j < exp_data.size() && j < log_data.size(); j++) begin
      ea = (j < MEM_WORDS) ? 32'(4 * j) : 32'(4 * (j - MEM_WORDS));
      checks++;
      if (log_addr[j] !== ea || log_data[j] !== exp_data[j]) begin
        failures++;
        $display("FAIL %s_write[%0d] got addr=%h data=%h expected addr=%h data=%h", name, j,
                 log_addr[j], log_data[j], ea, exp_data[j]);
      end
    end
    if (log_cyc.size() == 34 && acc_cyc.size() == 8) begin
      checks++;
      if (log_cyc[31] - log_cyc[0] !== MEM_WORDS - 1) begin
        failures++;
        $display("FAIL %s_clear_len got %0d expected %0d", name, log_cyc[31] - log_cyc[0] + 1,
                 MEM_WORDS);
      end
      checks++;
      if (log_cyc[32] !== acc_cyc[3]) begin
        failures++;
        $display("FAIL %s_wr_latency got cycle %0d expected %0d", name, log_cyc[32], acc_cyc[3]);
      end
      checks++;
      if (dcyc !== log_cyc[33] + 1) begin
        failures++;
        $display("FAIL %s_done_latency got cycle %0d expected %0d", name, dcyc, log_cyc[33] + 1);
      end
    end
    checks++;
    if ({words_o, done_o, cpu_hold_o, err_align_o, err_ovf_o} !== {6'd2, 4'b1000}) begin
      failures++;
      $display("FAIL %s_final got words=%0d done=%b hold=%b align=%b ovf=%b expected 2 1 0 0 0",
               name, words_o, done_o, cpu_hold_o, err_align_o, err_ovf_o);
    end
    checks++;
    if (ready_bad !== 0) begin
      failures++;
      $display("FAIL %s_ready_while_write got %0d expected 0", name, ready_bad);
    end
  endtask

  task automatic test_basic();
    run_program("basic", 1'b0);
  endtask

  task automatic test_toggle();
    run_program("toggle", 1'b1);
  endtask

  task automatic test_align();
    bit ok;
    bit dok;
    int dcyc;
    clear_logs();
    exp_data.push_back(32'h11223344);
    exp_data.push_back(32'hAABB0000);
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    pulse_start();
    send_stream(1'b0, 1'b1, ok);
    wait_done(dok, dcyc);
    checks++;
    if ({ok, dok} !== 2'b11) begin
      failures++;
      $display("FAIL align_timeout got sent=%b done=%b expected 11", ok, dok);
    end
    checks++;
    if (log_data.size() !== 34) begin
      failures++;
      $display("FAIL align_nwrites got %0d expected 34", log_data.size());
    end else begin
      checks++;
      if (log_addr[32] !== 32'h0 || log_data[32] !== 32'h11223344 ||
          log_addr[33] !== 32'h4 || log_data[33] !== 32'hAABB0000) begin
        failures++;
        $display("FAIL align_data got %h@%h %h@%h expected 11223344@0 aabb0000@4",
                 log_data[32], log_addr[32], log_data[33], log_addr[33]);
      end
    end
    checks++;
    if ({err_align_o, err_ovf_o, words_o} !== {2'b10, 6'd2}) begin
      failures++;
      $display("FAIL align_flags got align=%b ovf=%b words=%0d expected 1 0 2", err_align_o,
               err_ovf_o, words_o);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    bit dok;
    int dcyc;
    logic [31:0] ed;
    logic [7:0]  b;
    clear_logs();
    stream.delete();
    for (int i = 0; i < 132; i++) stream.push_back(8'(i));
    pulse_start();
    send_stream(1'b0, 1'b1, ok);
    wait_done(dok, dcyc);
    checks++;
    if ({ok, dok} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_timeout got sent=%b done=%b expected 11", ok, dok);
    end
    checks++;
    if (log_data.size() !== 64) begin
      failures++;
      $display("FAIL ovf_nwrites got %0d expected 64", log_data.size());
    end
    for (int w = 0; w < MEM_WORDS && (w + MEM_WORDS) < log_data.size(); w++) begin
      b = 8'(4 * w);
      ed = {b, b + 8'd1, b + 8'd2, b + 8'd3};
      checks++;
      if (log_addr[w + MEM_WORDS] !== 32'(4 * w) || log_data[w + MEM_WORDS] !== ed) begin
        failures++;
        $display("FAIL ovf_write[%0d] got addr=%h data=%h expected addr=%h data=%h", w,
                 log_addr[w + MEM_WORDS], log_data[w + MEM_WORDS], 32'(4 * w), ed);
      end
    end
    checks++;
    if ({err_ovf_o, err_align_o, words_o, done_o} !== {2'b10, 6'd32, 1'b1}) begin
      failures++;
      $display("FAIL ovf_flags got ovf=%b align=%b words=%0d done=%b expected 1 0 32 1",
               err_ovf_o, err_align_o, words_o, done_o);
    end
  endtask

  task automatic test_start_restart();
    bit ok;
    bit ok2;
    bit dok;
    int dcyc;
    clear_logs();
    pulse_start();
    stream = '{8'h11, 8'h22};
    send_stream(1'b0, 1'b0, ok);
    pulse_start();  // ignored in RECV
    stream = '{8'h33, 8'h44, 8'h55};
    send_stream(1'b0, 1'b1, ok2);
    wait_done(dok, dcyc);
    checks++;
    if ({ok, ok2, dok} !== 3'b111) begin
      failures++;
      $display("FAIL ign_timeout got %b expected 111", {ok, ok2, dok});
    end
    checks++;
    if (log_data.size() !== 34) begin
      failures++;
      $display("FAIL ign_nwrites got %0d expected 34", log_data.size());
    end else begin
      checks++;
      if (log_data[32] !== 32'h11223344 || log_data[33] !== 32'h55000000) begin
        failures++;
        $display("FAIL ign_data got %h %h expected 11223344 55000000", log_data[32],
                 log_data[33]);
      end
    end
    checks++;
    if ({err_align_o, words_o} !== {1'b1, 6'd2}) begin
      failures++;
      $display("FAIL ign_flags got align=%b words=%0d expected 1 2", err_align_o, words_o);
    end
    // Restart from DONE.
    clear_logs();
    pulse_start();
    checks++;
    if ({done_o, err_align_o, err_ovf_o, cpu_hold_o, words_o} !== {4'b0001, 6'd0}) begin
      failures++;
      $display("FAIL restart_state got done=%b align=%b ovf=%b hold=%b words=%0d expected 0 0 0 1 0",
               done_o, err_align_o, err_ovf_o, cpu_hold_o, words_o);
    end
    stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_stream(1'b0, 1'b1, ok);
    wait_done(dok, dcyc);
    checks++;
    if (log_data.size() !== 33) begin
      failures++;
      $display("FAIL restart_nwrites got %0d expected 33 (ok=%b done=%b)", log_data.size(), ok,
               dok);
    end else begin
      checks++;
      if (log_addr[31] !== 32'h7C || log_data[31] !== 32'h0 ||
          log_addr[32] !== 32'h0 || log_data[32] !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL restart_data got %h@%h %h@%h expected 0@7c deadbeef@0", log_data[31],
                 log_addr[31], log_data[32], log_addr[32]);
      end
    end
    checks++;
    if ({words_o, err_align_o, done_o} !== {6'd1, 2'b01}) begin
      failures++;
      $display("FAIL restart_final got words=%0d align=%b done=%b expected 1 0 1", words_o,
               err_align_o, done_o);
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_i       = 8'h0;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    test_reset();
    test_basic();
    test_toggle();
    test_align();
    test_overflow();
    test_start_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
